// File: rtl/subbytes_iter.sv
// subbytes_iter: AES SubBytes (forward/inverse) over 16/LANES cycles with valid/ready handshakes
module subbytes_iter #(
    parameter int LANES  = 4,
    parameter int INV_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_inv,
    output logic         busy
);
    localparam int BEATS = 16 / LANES;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    // Byte x of each table sits at bits [8*(255-x) +: 8], i.e. entry 0 is the leftmost byte.
    localparam logic [2047:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        r_state;
    logic [127:0]  r_work;
    logic [CW-1:0] r_cnt;
    logic          r_mode;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [127:0]  r_out_data;
    logic          r_out_inv;
    logic          r_busy;

    logic [6:0]    w_base;
    logic [7:0]    w_lane_in [LANES];
    logic [7:0]    w_fwd     [LANES];
    logic [7:0]    w_inv     [LANES];
    logic [127:0]  w_next;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    assign w_base = 7'(int'(r_cnt) * LANES * 8);

    // Gather the bytes handled in the current beat, one per lane
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_lane_in[l] = r_work[w_base + 7'(l * 8) +: 8];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_fwd[l] = FWD[{~w_lane_in[l], 3'b000} +: 8];
        if (INV_EN != 0) begin : g_inv
            assign w_inv[l] = INV[{~w_lane_in[l], 3'b000} +: 8];
        end else begin : g_no_inv
            assign w_inv[l] = 8'h00;
        end
    end

    // Working register with this beat's bytes substituted, all other bytes untouched
    always_comb begin
        w_next = r_work;
        for (int l = 0; l < LANES; l++) begin
            w_next[w_base + 7'(l * 8) +: 8] = r_mode ? w_inv[l] : w_fwd[l];
        end
    end

    // Control FSM with registered handshake outputs; result is captured into out_data on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_inv   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_work     <= in_data;
                    r_mode     <= in_inv && (INV_EN != 0);
                    r_cnt      <= '0;
                    r_state    <= S_BUSY;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b1;
                end
                S_BUSY: begin
                    r_work <= w_next;
                    if (r_cnt == LAST) begin
                        r_cnt       <= '0;
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_next;
                        r_out_inv   <= r_mode;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: if (out_ready) begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_inv   = r_out_inv;
    assign busy      = r_busy;
endmodule

// File: tb/tb_subbytes_iter.sv
// tb_subbytes_iter: randomized and directed checks of subbytes_iter against a GF(2^8) S-box model
module tb_subbytes_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h638293c31bfc33f5c4eeacea4bc12816;

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol(logic [7:0] b, int n);
        logic [15:0] t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(logic [7:0] x);
        logic [7:0] y = 8'h01;
        for (int i = 0; i < 254; i++) y = gmul(y, x);
        return y ^ rol(y, 1) ^ rol(y, 2) ^ rol(y, 3) ^ rol(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] subst(logic [127:0] d, logic inv);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[8*j +: 8] = inv ? inv_t[d[8*j +: 8]] : fwd_t[d[8*j +: 8]];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // main DUT, LANES=4
    logic         rst = 1'b1, in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready, out_valid, out_inv, busy;
    logic [127:0] out_data;

    subbytes_iter #(.LANES(4), .INV_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_inv(out_inv), .busy(busy)
    );

    // behavioural model: one state in flight, result appears 4 edges after accept
    logic         m_busy = 0, m_valid = 0, m_mode = 0, m_oinv = 0;
    logic [127:0] m_work = '0, m_out = '0;
    int           m_left = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_valid = 0; m_mode = 0; m_oinv = 0; m_out = '0; m_left = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_valid = 1; m_out = m_work; m_oinv = m_mode;
            end
        end else if (m_valid) begin
            if (out_ready) m_valid = 0;
        end else if (in_valid) begin
            m_busy = 1; m_left = 4; m_work = subst(in_data, in_inv); m_mode = in_inv;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, !m_busy && !m_valid);
        chk("busy", busy, m_busy);
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_out);
        chk("out_inv", out_inv, m_oinv);
    end

    // extra instances: LANES 1,2,4,8,16 with inverse, and LANES=4 without inverse
    logic         a_rst [6], a_iv [6], a_ii [6], a_or [6];
    logic [127:0] a_id [6];
    logic         a_ir [6], a_ov [6], a_oi [6], a_busy [6];
    logic [127:0] a_od [6];

    for (genvar g = 0; g < 6; g++) begin : g_cfg
        subbytes_iter #(.LANES(g == 5 ? 4 : (1 << g)), .INV_EN(g == 5 ? 0 : 1)) u (
            .clk(clk), .rst(a_rst[g]), .in_valid(a_iv[g]), .in_ready(a_ir[g]), .in_data(a_id[g]),
            .in_inv(a_ii[g]), .out_valid(a_ov[g]), .out_ready(a_or[g]), .out_data(a_od[g]),
            .out_inv(a_oi[g]), .busy(a_busy[g])
        );
    end

    task automatic xfer(input int idx, input logic [127:0] d, input logic inv,
                        output logic [127:0] q, output logic qi, output int lat);
        int w = 0;
        while (!a_ir[idx] && w < 50) begin @(negedge clk); w++; end
        chk($sformatf("c%0d_ready_wait", idx), a_ir[idx], 1'b1);
        a_iv[idx] = 1; a_id[idx] = d; a_ii[idx] = inv;
        @(negedge clk);
        a_iv[idx] = 0; a_id[idx] = {4{$urandom}}; a_ii[idx] = 1'($urandom);
        lat = 0;
        while (!a_ov[idx] && lat < 40) begin @(negedge clk); lat++; end
        q = a_od[idx]; qi = a_oi[idx];
        a_or[idx] = 1;
        @(negedge clk);
        a_or[idx] = 0;
        chk($sformatf("c%0d_ready_after", idx), a_ir[idx], 1'b1);
    endtask

    task automatic send_main(input logic [127:0] d, input logic inv,
                             input logic [127:0] exp, input logic expi, input string nm);
        int w = 0, lat = 0, nb = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        in_valid = 1; in_data = d; in_inv = inv;
        @(negedge clk);
        in_valid = 0; in_data = {4{$urandom}}; in_inv = 1'($urandom);
        while (!out_valid && lat < 40) begin
            if (busy) nb++;
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 128'(lat), 128'(4));
        chk({nm, "_busy_cycles"}, 128'(nb), 128'(4));
        chk({nm, "_data"}, out_data, exp);
        chk({nm, "_inv"}, out_inv, expi);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk({nm, "_ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] q, d, r, exp;
        logic         qi;
        int           lat, beats;
        for (int i = 0; i < 6; i++) begin
            a_rst[i] = 1; a_iv[i] = 0; a_ii[i] = 0; a_or[i] = 0; a_id[i] = '0;
        end
        for (int x = 0; x < 256; x++) fwd_t[x] = sbox_calc(8'(x));
        for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
        chk("model_fwd_00", fwd_t[8'h00], 8'h63);
        chk("model_fwd_53", fwd_t[8'h53], 8'hed);
        chk("model_inv_ed", inv_t[8'hed], 8'h53);
        chk("model_inv_16", inv_t[8'h16], 8'hff);
        chk("model_vector", subst(PT, 0), CT);

        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 6; i++) a_rst[i] = 0;
        @(negedge clk);

        send_main(PT, 0, CT, 0, "fips_fwd");
        send_main(CT, 1, PT, 1, "fips_inv");
        send_main({{13{8'h63}}, 8'h16, 8'hed, 8'h63}, 1, {{13{8'h00}}, 8'hff, 8'h53, 8'h00}, 1, "inv_bytes");

        // backpressure: result held while out_ready is low, new input ignored
        d = {4{$urandom}};
        in_valid = 1; in_data = d; in_inv = 0;
        @(negedge clk);
        in_valid = 0;
        for (int w = 0; w < 40 && !out_valid; w++) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1; in_data = {4{$urandom}}; in_inv = 1;
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_data", out_data, subst(d, 0));
            chk("bp_out_inv", out_inv, 1'b0);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("bp_ready_back", in_ready, 1'b1);
        chk("bp_valid_drop", out_valid, 1'b0);

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(9) < 6);
            in_data = {4{$urandom}};
            in_inv = 1'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
        end
        in_valid = 0; out_ready = 1;
        repeat (6) @(negedge clk);
        out_ready = 0;

        // every byte value in both modes, latency and round trip for each configuration
        for (int idx = 0; idx < 6; idx++) begin
            beats = (idx == 5) ? 4 : (16 >> idx);
            for (int s = 0; s < 16; s++) begin
                for (int j = 0; j < 16; j++) d[8*j +: 8] = 8'(s * 16 + j);
                xfer(idx, d, 0, q, qi, lat);
                chk($sformatf("c%0d_lat", idx), 128'(lat), 128'(beats));
                chk($sformatf("c%0d_fwd", idx), q, subst(d, 0));
                chk($sformatf("c%0d_fwd_inv", idx), qi, 1'b0);
                xfer(idx, d, 1, r, qi, lat);
                chk($sformatf("c%0d_inv", idx), r, subst(d, idx != 5));
                chk($sformatf("c%0d_inv_flag", idx), qi, idx != 5);
                if (idx != 5) begin
                    xfer(idx, r, 0, q, qi, lat);
                    chk($sformatf("c%0d_roundtrip", idx), q, d);
                end
            end
        end
        xfer(5, '0, 1, q, qi, lat);
        chk("noinv_zero_data", q, {16{8'h63}});
        chk("noinv_zero_inv", qi, 1'b0);

        // asynchronous reset in the middle of a LANES=1 substitution
        xfer(0, PT, 0, q, qi, lat);
        a_iv[0] = 1; a_id[0] = CT; a_ii[0] = 1;
        @(negedge clk);
        a_iv[0] = 0;
        repeat (7) @(negedge clk);
        chk("rst_busy_before", a_busy[0], 1'b1);
        a_rst[0] = 1;
        #1;
        chk("rst_out_valid", a_ov[0], 1'b0);
        chk("rst_in_ready", a_ir[0], 1'b1);
        chk("rst_busy", a_busy[0], 1'b0);
        chk("rst_out_data", a_od[0], 128'h0);
        chk("rst_out_inv", a_oi[0], 1'b0);
        @(negedge clk);
        a_rst[0] = 0;
        xfer(0, PT, 0, q, qi, lat);
        chk("after_rst_data", q, CT);
        chk("after_rst_lat", 128'(lat), 128'(16));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
